// File: rtl/imem_boot_sequencer.sv
// Boot/run controller for the single-cycle RV32I core: streams a program into
// instruction memory, releases the core, and watches for the halt idiom or a timeout.
module imem_boot_sequencer #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_W     = $clog2(DEPTH),
    parameter int unsigned MAX_CYCLES = 1024,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0063
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    input  logic [31:0]       core_pc,
    input  logic [31:0]       core_instr,
    output logic              busy,
    output logic              halted,
    output logic              timeout,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       cycle_count,
    output logic [31:0]       halt_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_HALTED,
        S_TIMEOUT,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [31:0]     CYC_LAST  = 32'(MAX_CYCLES - 1);
    localparam logic [31:0]     CYC_LIMIT = 32'(MAX_CYCLES);

    state_t state;
    state_t state_nxt;
    logic   hs;
    logic   load_go;

    always_comb begin
        hs        = load_valid & load_ready;
        state_nxt = state;
        unique case (state)
            S_IDLE, S_ERROR: begin
                if (load_start) state_nxt = S_LOAD;
            end
            S_HALTED, S_TIMEOUT: begin
                if (load_start)     state_nxt = S_LOAD;
                else if (run_start) state_nxt = S_RELEASE;
            end
            S_LOAD: begin
                if (hs) begin
                    if (load_last)                  state_nxt = S_RELEASE;
                    else if (word_count == LAST_IDX) state_nxt = S_ERROR;
                end
            end
            S_RELEASE: state_nxt = S_RUN;
            S_RUN: begin
                if (core_instr == HALT_INSTR)   state_nxt = S_HALTED;
                else if (cycle_count == CYC_LAST) state_nxt = S_TIMEOUT;
            end
            default: state_nxt = S_IDLE;
        endcase
        load_go = (state_nxt == S_LOAD) && (state != S_LOAD);
    end

    // Status flags and core_reset_n are registered from the next state so they
    // line up exactly with the cycles spent in each state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            load_ready   <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            timeout      <= 1'b0;
            load_err     <= 1'b0;
            core_reset_n <= 1'b0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            word_count   <= '0;
            cycle_count  <= '0;
            halt_pc      <= '0;
        end else begin
            state        <= state_nxt;
            load_ready   <= (state_nxt == S_LOAD);
            busy         <= (state_nxt == S_LOAD) || (state_nxt == S_RELEASE) ||
                            (state_nxt == S_RUN);
            halted       <= (state_nxt == S_HALTED);
            timeout      <= (state_nxt == S_TIMEOUT);
            load_err     <= (state_nxt == S_ERROR);
            core_reset_n <= (state_nxt == S_RUN) || (state_nxt == S_HALTED) ||
                            (state_nxt == S_TIMEOUT);

            imem_we <= hs;
            if (hs) begin
                imem_waddr <= word_count[ADDR_W-1:0];
                imem_wdata <= load_data;
            end

            if (load_go)  word_count <= '0;
            else if (hs)  word_count <= word_count + 1'b1;

            if (state == S_RELEASE) begin
                cycle_count <= '0;
                halt_pc     <= '0;
            end else if (state == S_RUN) begin
                if (cycle_count < CYC_LIMIT) cycle_count <= cycle_count + 32'd1;
                if (state_nxt == S_HALTED)   halt_pc <= core_pc;
            end
        end
    end

endmodule

// File: doc/imem_boot_sequencer.md
Name: imem_boot_sequencer

Overview:
- Boot and run controller for the single-cycle RV32I datapath.
- Accepts a program as a valid/ready word stream and writes it into instruction memory through a dedicated write port, holding the core in reset while it loads.
- Releases the core, then monitors fetched instructions for the halt idiom (beq x0,x0,0) or a cycle timeout.
- Reports run status, cycle count and halt PC, so benches and boot ROM logic no longer poke instruction memory hierarchically.

Parameters:
- DEPTH, 64, instruction memory depth in 32-bit words; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), word-address width of the imem write port.
- MAX_CYCLES, 1024, number of run cycles allowed before TIMEOUT; must be at least 1.
- HALT_INSTR, 32'h0000_0063, halt encoding (beq x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load_start  in  1  pulse; begins a program load.
- run_start  in  1  pulse; re-runs the loaded program without reloading.
- load_valid  in  1  stream word valid.
- load_ready  out  1  sequencer accepts a stream word.
- load_data  in  32  instruction word.
- load_last  in  1  marks the final word of the program.
- imem_we  out  1  instruction memory write enable.
- imem_waddr  out  ADDR_W  word address.
- imem_wdata  out  32  write data.
- core_reset_n  out  1  active-low reset to the datapath.
- core_pc  in  32  datapath current PC.
- core_instr  in  32  datapath current fetched instruction.
- busy  out  1  high in LOAD, RELEASE or RUN.
- halted  out  1  high in HALTED.
- timeout  out  1  high in TIMEOUT.
- load_err  out  1  high in ERROR.
- word_count  out  ADDR_W+1  number of words accepted in the last load.
- cycle_count  out  32  run cycles consumed.
- halt_pc  out  32  PC captured at halt detection.

Behaviour:
- States: IDLE, LOAD, RELEASE, RUN, HALTED, TIMEOUT, ERROR.
- Reset values:
  - State is IDLE.
  - All outputs are 0, including core_reset_n (core is held in reset).
  - word_count, cycle_count and halt_pc are 0.
- Reset mid-operation aborts immediately to the reset values. Instruction memory contents are not cleared.
- load_start is accepted in IDLE, HALTED, TIMEOUT and ERROR, and ignored in LOAD, RELEASE and RUN.
  - On acceptance: go to LOAD, clear word_count, drive core_reset_n=0.
- run_start is accepted only in HALTED and TIMEOUT, and goes to RELEASE.
- If load_start and run_start are both asserted in the same cycle, load_start wins.
- LOAD:
  - load_ready=1.
  - A handshake (load_valid & load_ready) registers imem_we=1, imem_waddr=word_count[ADDR_W-1:0] and imem_wdata=load_data, visible the next cycle. Write latency is 1 cycle; imem_we is otherwise 0.
  - word_count increments by 1 per handshake.
  - Handshake with load_last=1: go to RELEASE.
  - Handshake with load_last=0 when word_count==DEPTH-1: the word is written, word_count becomes DEPTH, then go to ERROR (overflow).
  - load_valid low: hold state.
- RELEASE:
  - Lasts exactly 1 cycle with core_reset_n=0, so the final write lands before fetch.
  - Clears cycle_count and halt_pc, then goes to RUN.
- core_reset_n is registered: it is 1 exactly in cycles where the state is RUN, HALTED or TIMEOUT.
- RUN:
  - cycle_count increments by 1 every RUN cycle, including the exit cycle.
  - If core_instr==HALT_INSTR: capture halt_pc=core_pc and go to HALTED.
  - Else if cycle_count==MAX_CYCLES-1: go to TIMEOUT.
  - If both conditions hold in the same cycle, halt wins.
- HALTED and TIMEOUT:
  - The core keeps running, so architectural state stays observable.
  - cycle_count and halt_pc are frozen.
- ERROR:
  - The core is held in reset.
  - Only load_start (or reset) exits.
- load_ready is 0 outside LOAD. Stream words offered outside LOAD are not consumed.
- cycle_count saturates at MAX_CYCLES and never wraps.

Test Plan:
- Load 27 words (last on word 26, word 26 = 0x00000063) with load_valid continuously high. Required:
  - 27 imem writes at addresses 0..26, each one cycle after its handshake.
  - word_count=27.
  - core_reset_n low through RELEASE, then high.
  - halted=1 with halt_pc=0x68.
- Load with load_valid toggling every other cycle. Required: writes occur only on handshake cycles and addresses stay contiguous with no gaps or duplicates.
- Program with no halt (jal x0,0 loop) and MAX_CYCLES=16. Required: timeout=1 with cycle_count=16, and core_reset_n stays 1.
- DEPTH=8, stream 9 words with no load_last. Required:
  - 8 writes, word_count=8, load_err=1, core_reset_n=0.
  - A 9th word is offered but load_ready=0, so it is not consumed.
  - A subsequent load_start recovers to LOAD.
- From HALTED, pulse run_start. Required:
  - One RELEASE cycle with core_reset_n=0.
  - cycle_count restarts from 0.
  - Same halt_pc and same cycle_count as the first run.
- Assert reset_n low mid-LOAD and mid-RUN. Required:
  - Outputs return to reset values immediately (asynchronous).
  - State is IDLE.
  - load_start and run_start pulsed while the state is RUN are ignored.
